// File: rtl/fader_sched.sv
// fader_sched: issues periodic fader runs and double-buffers the returned coefficients
module fader_sched #(
  parameter int NCHAN   = 32,
  parameter int CHW     = 5,
  parameter int TW      = 25,
  parameter int DW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [15:0]   period,
  input  logic          err_clr,
  output logic          fader_start,
  output logic [TW-1:0] fader_t_index,
  input  logic          fader_dv,
  input  logic [CHW-1:0] fader_chan,
  input  logic [DW-1:0] fader_zr,
  input  logic [DW-1:0] fader_zi,
  input  logic [CHW-1:0] rd_chan,
  output logic [DW-1:0] rd_real,
  output logic [DW-1:0] rd_imag,
  output logic          coef_update,
  output logic          busy,
  output logic          err_overrun,
  output logic          err_timeout,
  output logic          err_dup,
  output logic          err_stray
);
  localparam int TOW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, START, WAIT, SWAP, HOLD} state_t;
  state_t state, nxt;
  logic [TW-1:0] t_cnt;
  logic [15:0] pcnt, pmax;
  logic [TOW-1:0] tcnt;
  logic [NCHAN-1:0] mask, mask_nxt;
  logic sel, dv_w, full, tout;
  logic [2*DW-1:0] bank [0:1][0:NCHAN-1];
  assign pmax = (period < 16'd2) ? 16'd2 : period;
  assign dv_w = (state == WAIT) && fader_dv;
  assign mask_nxt = mask | ({{(NCHAN-1){1'b0}}, dv_w} << fader_chan);
  assign full = &mask_nxt;
  assign tout = (tcnt == TOW'(TIMEOUT - 1));
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  // next-state logic; a completing delivery beats a same-cycle timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = enable ? START : IDLE;
      START:   nxt = WAIT;
      WAIT:    nxt = full ? SWAP : (tout ? HOLD : WAIT);
      SWAP:    nxt = HOLD;
      HOLD:    nxt = !enable ? IDLE : ((pcnt >= pmax - 16'd1) ? START : HOLD);
      default: nxt = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    fader_start = (state == START);
    coef_update = (state == SWAP);
    busy        = (state == START) || (state == WAIT);
  end
  // run counters, receive mask, time index and bank select; pcnt holds cycles elapsed since the START cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      t_cnt         <= '0;
      fader_t_index <= '0;
      pcnt          <= '0;
      tcnt          <= '0;
      mask          <= '0;
      sel           <= 1'b0;
    end else begin
      pcnt <= (state == START) ? 16'd1 : ((&pcnt) ? pcnt : pcnt + 16'd1);
      tcnt <= (state == START) ? '0 : ((state == WAIT) ? tcnt + TOW'(1) : tcnt);
      mask <= (state == START) ? '0 : mask_nxt;
      if (nxt == START) fader_t_index <= t_cnt;
      if (state == SWAP) begin
        sel   <= ~sel;
        t_cnt <= t_cnt + TW'(1);
      end
    end
  // coefficient banks: writes go to the shadow bank, reads come from the active bank before any swap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < NCHAN; c++) bank[b][c] <= '0;
      rd_real <= '0;
      rd_imag <= '0;
    end else begin
      if (dv_w) bank[~sel][fader_chan] <= {fader_zr, fader_zi};
      {rd_real, rd_imag} <= bank[sel][rd_chan];
    end
  // sticky errors; a same-cycle event overrides err_clr
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      err_dup     <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      err_overrun <= ((state == WAIT) && (pcnt == pmax - 16'd1)) || (err_overrun && !err_clr);
      err_timeout <= ((state == WAIT) && tout && !full) || (err_timeout && !err_clr);
      err_dup     <= (dv_w && mask[fader_chan]) || (err_dup && !err_clr);
      err_stray   <= (fader_dv && (state != WAIT)) || (err_stray && !err_clr);
    end
endmodule

// File: tb/tb_fader_sched.sv
// tb_fader_sched: randomized fader runs checked against a bank/time-index model of the sequencer
module tb_fader_sched;
  localparam int NCHAN = 32, CHW = 5, TW = 4, DW = 16, TIMEOUT = 4096;
  logic clk = 0, reset = 1, enable = 0, err_clr = 0, fader_dv = 0;
  logic [15:0] period = 16'd100;
  logic [CHW-1:0] fader_chan = '0, rd_chan = 5'd7;
  logic [DW-1:0] fader_zr = '0, fader_zi = '0;
  logic fader_start, coef_update, busy, err_overrun, err_timeout, err_dup, err_stray;
  logic [TW-1:0] fader_t_index;
  logic [DW-1:0] rd_real, rd_imag;
  int errors = 0, checks = 0, cyc = 0, n_start = 0, n_upd = 0;
  int exp_t = 0, exp_next = -1, exp_upd = 0;
  bit e_ovr = 0, e_to = 0, e_dup = 0, e_stray = 0;
  logic [DW-1:0] act_r [NCHAN], act_i [NCHAN];

  fader_sched #(.NCHAN(NCHAN), .CHW(CHW), .TW(TW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period), .err_clr(err_clr),
    .fader_start(fader_start), .fader_t_index(fader_t_index), .fader_dv(fader_dv),
    .fader_chan(fader_chan), .fader_zr(fader_zr), .fader_zi(fader_zi), .rd_chan(rd_chan),
    .rd_real(rd_real), .rd_imag(rd_imag), .coef_update(coef_update), .busy(busy),
    .err_overrun(err_overrun), .err_timeout(err_timeout), .err_dup(err_dup), .err_stray(err_stray)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (fader_start) n_start <= n_start + 1;
    if (coef_update) n_upd <= n_upd + 1;
  end

  // one fader run: mode 0 in order, 1 reverse with chan 3 repeated, 2 chan 12 dropped
  task automatic serve(input int lat, input int mode, input bit last);
    int q[$];
    int s, w, hold, lastw, pm;
    bit seen [NCHAN];
    bit complete;
    logic [DW-1:0] pr [NCHAN], pi [NCHAN];
    for (int i = 0; i < 10000 && fader_start !== 1'b1; i++) @(negedge clk);
    checks++;
    if (fader_start !== 1'b1) begin
      errors++;
      $display("FAIL start_wait: fader_start=%b required 1", fader_start);
      return;
    end
    s = cyc;
    pm = (period < 2) ? 2 : int'(period);
    checks++;
    if (fader_t_index !== TW'(exp_t)) begin
      errors++;
      $display("FAIL t_index: got %0d required %0d", fader_t_index, exp_t);
    end
    if (exp_next >= 0) begin
      checks++;
      if (s != exp_next) begin
        errors++;
        $display("FAIL start_cycle: got %0d required %0d", s, exp_next);
      end
    end
    for (int c = 0; c < NCHAN; c++) begin
      seen[c] = 0; pr[c] = act_r[c]; pi[c] = act_i[c];
    end
    if (mode == 1) begin
      for (int c = NCHAN - 1; c >= 0; c--) begin
        q.push_back(c);
        if (c == 3) q.push_back(3);
      end
    end else begin
      for (int c = 0; c < NCHAN; c++) if (!(mode == 2 && c == 12)) q.push_back(c);
    end
    rd_chan = 5'd7;
    repeat (lat) @(negedge clk);
    if (last) enable = 0;
    foreach (q[k]) begin
      fader_dv = 1;
      fader_chan = CHW'(q[k]);
      fader_zr = DW'($urandom);
      fader_zi = DW'($urandom);
      pr[q[k]] = fader_zr;
      pi[q[k]] = fader_zi;
      if (seen[q[k]]) e_dup = 1;
      seen[q[k]] = 1;
      @(negedge clk);
    end
    fader_dv = 0;
    complete = 1;
    for (int c = 0; c < NCHAN; c++) if (!seen[c]) complete = 0;
    if (complete) begin
      w = cyc;
      checks++;
      if (coef_update !== 1'b1) begin
        errors++;
        $display("FAIL coef_update: got %b required 1", coef_update);
      end
      checks++;
      if (rd_real !== act_r[7] || rd_imag !== act_i[7]) begin
        errors++;
        $display("FAIL rd_before_swap: got %h/%h required %h/%h", rd_real, rd_imag, act_r[7], act_i[7]);
      end
      @(negedge clk);
      checks++;
      if (rd_real !== act_r[7] || rd_imag !== act_i[7]) begin
        errors++;
        $display("FAIL rd_swap_edge: got %h/%h required %h/%h", rd_real, rd_imag, act_r[7], act_i[7]);
      end
      for (int c = 0; c < NCHAN; c++) begin
        act_r[c] = pr[c]; act_i[c] = pi[c];
      end
      exp_t = (exp_t + 1) % (1 << TW);
      exp_upd++;
      @(negedge clk);
      checks++;
      if (rd_real !== act_r[7] || rd_imag !== act_i[7]) begin
        errors++;
        $display("FAIL rd_after_swap: got %h/%h required %h/%h", rd_real, rd_imag, act_r[7], act_i[7]);
      end
      hold = w + 1;
      lastw = w - 1;
    end else begin
      while (cyc < s + TIMEOUT) @(negedge clk);
      checks++;
      if (err_timeout !== e_to) begin
        errors++;
        $display("FAIL timeout_early: got %b required %b", err_timeout, e_to);
      end
      @(negedge clk);
      e_to = 1;
      hold = cyc;
      lastw = cyc - 1;
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL timeout_flag: err_timeout=%b busy=%b required 1/0", err_timeout, busy);
      end
      checks++;
      if (rd_real !== act_r[7] || rd_imag !== act_i[7]) begin
        errors++;
        $display("FAIL rd_old_bank: got %h/%h required %h/%h", rd_real, rd_imag, act_r[7], act_i[7]);
      end
    end
    if (lastw >= s + pm - 1) e_ovr = 1;
    exp_next = (s + pm > hold + 1) ? s + pm : hold + 1;
    checks++;
    if ({err_overrun, err_timeout, err_dup, err_stray} !== {e_ovr, e_to, e_dup, e_stray}) begin
      errors++;
      $display("FAIL err_flags: got %b%b%b%b required %b%b%b%b", err_overrun, err_timeout, err_dup,
               err_stray, e_ovr, e_to, e_dup, e_stray);
    end
    checks++;
    if (n_upd != exp_upd) begin
      errors++;
      $display("FAIL update_count: got %0d required %0d", n_upd, exp_upd);
    end
  endtask

  task automatic test_reset();
    #2 reset = 0;
    for (int c = 0; c < NCHAN; c++) begin
      act_r[c] = '0; act_i[c] = '0;
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({fader_start, coef_update, busy, err_overrun, err_timeout, err_dup, err_stray} !== 7'd0 ||
        fader_t_index !== '0 || rd_real !== '0 || rd_imag !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b upd=%b busy=%b t=%0d rd=%h/%h required all 0",
               fader_start, coef_update, busy, fader_t_index, rd_real, rd_imag);
    end
    reset = 1;
    @(negedge clk);
  endtask

  task automatic clear_errs();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    e_ovr = 0; e_to = 0; e_dup = 0; e_stray = 0;
  endtask

  task automatic test_periodic();
    exp_next = -1; period = 100; enable = 1;
    serve(40, 0, 0);
    serve(40, 0, 0);
    serve(40, 0, 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = $urandom_range(NCHAN - 1);
      rd_chan = CHW'(c);
      repeat (2) @(negedge clk);
      checks++;
      if (rd_real !== act_r[c] || rd_imag !== act_i[c]) begin
        errors++;
        $display("FAIL readback ch%0d: got %h/%h required %h/%h", c, rd_real, rd_imag, act_r[c], act_i[c]);
      end
    end
  endtask

  task automatic test_dup();
    clear_errs();
    exp_next = -1; period = 100; enable = 1;
    serve(5, 1, 1);
    rd_chan = 5'd3;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_real !== act_r[3] || rd_imag !== act_i[3]) begin
      errors++;
      $display("FAIL dup_last_value: got %h/%h required %h/%h", rd_real, rd_imag, act_r[3], act_i[3]);
    end
  endtask

  task automatic test_timeout();
    repeat (3) @(negedge clk);
    clear_errs();
    exp_next = -1; period = 100; enable = 1;
    serve(5, 2, 0);
    serve(5, 0, 1);
  endtask

  task automatic test_overrun();
    repeat (3) @(negedge clk);
    clear_errs();
    exp_next = -1; period = 20; enable = 1;
    serve(8, 0, 0);
    serve(8, 0, 0);
    period = 0; exp_next = -1;
    serve(3, 0, 0);
    serve(3, 0, 1);
  endtask

  task automatic test_wrap();
    repeat (3) @(negedge clk);
    clear_errs();
    exp_next = -1; period = 40; enable = 1;
    for (int i = 0; i < 20 && exp_t != (1 << TW) - 1; i++) serve(2, 0, 0);
    serve(2, 0, 0);
    serve(2, 0, 1);
  endtask

  task automatic test_reset_mid();
    int snap;
    repeat (3) @(negedge clk);
    clear_errs();
    period = 100; enable = 1;
    for (int i = 0; i < 1000 && fader_start !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      fader_dv = 1; fader_chan = CHW'(c); fader_zr = DW'($urandom); fader_zi = DW'($urandom);
      @(negedge clk);
    end
    fader_dv = 0;
    snap = n_upd;
    reset = 0;
    #1;
    checks++;
    if ({fader_start, coef_update, busy, err_overrun, err_timeout, err_dup, err_stray} !== 7'd0 ||
        fader_t_index !== '0 || rd_real !== '0 || rd_imag !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: start=%b upd=%b busy=%b t=%0d rd=%h/%h required all 0",
               fader_start, coef_update, busy, fader_t_index, rd_real, rd_imag);
    end
    for (int c = 0; c < NCHAN; c++) begin
      act_r[c] = '0; act_i[c] = '0;
    end
    exp_t = 0;
    enable = 0;
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (n_upd != snap || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_swap: updates=%0d busy=%b required %0d/0", n_upd, busy, snap);
    end
  endtask

  task automatic test_enable_drop();
    int snap;
    exp_next = -1; period = 100; enable = 1;
    serve(10, 0, 1);
    snap = n_start;
    repeat (300) @(negedge clk);
    checks++;
    if (n_start != snap || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_drop: starts=%0d busy=%b required %0d/0", n_start, busy, snap);
    end
  endtask

  task automatic test_stray();
    fader_dv = 1; fader_chan = 5'd5; fader_zr = DW'($urandom); fader_zi = DW'($urandom);
    @(negedge clk);
    fader_dv = 0;
    e_stray = 1;
    checks++;
    if ({err_overrun, err_timeout, err_dup, err_stray} !== {e_ovr, e_to, e_dup, e_stray}) begin
      errors++;
      $display("FAIL stray_flag: got %b%b%b%b required %b%b%b%b", err_overrun, err_timeout, err_dup,
               err_stray, e_ovr, e_to, e_dup, e_stray);
    end
    rd_chan = 5'd5;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_real !== act_r[5] || rd_imag !== act_i[5]) begin
      errors++;
      $display("FAIL stray_ignored: got %h/%h required %h/%h", rd_real, rd_imag, act_r[5], act_i[5]);
    end
    err_clr = 1; fader_dv = 1;
    @(negedge clk);
    fader_dv = 0;
    checks++;
    if (err_stray !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_event: err_stray=%b required 1", err_stray);
    end
    @(negedge clk);
    err_clr = 0;
    e_ovr = 0; e_to = 0; e_dup = 0; e_stray = 0;
    checks++;
    if ({err_overrun, err_timeout, err_dup, err_stray} !== 4'b0000) begin
      errors++;
      $display("FAIL err_clr: got %b%b%b%b required 0000", err_overrun, err_timeout, err_dup, err_stray);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_dup();
    test_timeout();
    test_overrun();
    test_wrap();
    test_reset_mid();
    test_enable_drop();
    test_stray();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
